// File: rtl/systolic_fifo_ctrl_if.sv
// Handshake and strobe bundle between the operand source, the FIFO sequencer and the row FIFOs.
// Latency: none, wires only.
// Backpressure: row_valid/row_ready on the row load path; stall on the drain path.
// Ports: start/busy/done control, row_valid/row_ready/row_data load handshake,
//        stall from the array, fifo_load/fifo_load_vals/fifo_shift strobes to the FIFOs.
// master = operand source / array side, slave = sequencer side.
interface systolic_fifo_ctrl_if #(
    parameter int N  = 4,
    parameter int DW = N * 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic          row_valid;
    logic          row_ready;
    logic [DW-1:0] row_data;
    logic          stall;
    logic [N-1:0]  fifo_load;
    logic [DW-1:0] fifo_load_vals;
    logic [N-1:0]  fifo_shift;

    modport master (
        output start, row_valid, row_data, stall,
        input  busy, done, row_ready, fifo_load, fifo_load_vals, fifo_shift
    );

    modport slave (
        input  start, row_valid, row_data, stall,
        output busy, done, row_ready, fifo_load, fifo_load_vals, fifo_shift
    );
endinterface

// File: rtl/systolic_fifo_ctrl.sv
// Sequencer for the N per-row systolic input FIFOs: loads N rows, then drains them with a diagonal skew.
// Latency: N load cycles + 2N-1 drain cycles + 1 done cycle (start-to-done 3N+1 with row_valid held).
// Backpressure: row_valid/row_ready throttles loading; stall freezes the drain, keeping the skew.
// Ports: clk, rst (async, active-high); bus (slave modport of systolic_fifo_ctrl_if).
// Optional: SYS_FIFO_CTRL_PERF_EN adds perf_busy_cyc / perf_stall_cyc saturating counters.
module systolic_fifo_ctrl #(
    parameter  int N  = 4,
    parameter  int DW = N * 8,
    localparam int CW = $clog2(2 * N),
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_fifo_ctrl_if.slave   bus
`ifdef SYS_FIFO_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] row_idx_nxt;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] dcnt_nxt;

    logic          row_ready;
    logic          done;
    logic [N-1:0]  fifo_load;
    logic [N-1:0]  fifo_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row_idx <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            dcnt    <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        dcnt_nxt    = dcnt;
        row_ready   = 1'b0;
        done        = 1'b0;
        fifo_load   = '0;
        fifo_shift  = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = LOAD;
                    row_idx_nxt = '0;
                end
            end
            LOAD: begin
                row_ready = 1'b1;
                if (bus.row_valid) begin
                    fifo_load[row_idx] = 1'b1;
                    // Last row: row_idx stays at N-1 so it never wraps.
                    if (row_idx == RW'(N - 1)) begin
                        state_nxt = DRAIN;
                        dcnt_nxt  = '0;
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // A stalled cycle neither shifts nor advances dcnt, so every
                // row keeps its offset from row 0 across the stall.
                if (!bus.stall) begin
                    for (int i = 0; i < N; i++) begin
                        fifo_shift[i] = (int'(dcnt) >= i) && (int'(dcnt) <= i + N - 1);
                    end
                    if (dcnt == CW'(2 * N - 2)) begin
                        state_nxt = DONE;
                    end else begin
                        dcnt_nxt = dcnt + 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy           = (state != IDLE);
    assign bus.done           = done;
    assign bus.row_ready      = row_ready;
    assign bus.fifo_load      = fifo_load;
    assign bus.fifo_shift     = fifo_shift;
    // Same row broadcast to every FIFO; only the strobed one captures it.
    assign bus.fifo_load_vals = bus.row_data;

`ifdef SYS_FIFO_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if ((state == IDLE) && bus.start) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if ((state != IDLE) && (perf_busy_cyc != 32'hFFFF_FFFF)) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if ((state == DRAIN) && bus.stall && (perf_stall_cyc != 32'hFFFF_FFFF)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
